add_round_keys_seq: RTL and testbench
=====================================

# add_round_keys_seq

Parametrised, sequential successor to the combinational AddRoundKey stage. It holds an on-chip bank of NUM_KEYS 128-bit round keys and accepts a 128-bit state plus a round index over a valid/ready handshake. It XORs the state with the selected key over 128/DATA_W beats, trading area for latency, and presents the result on a valid/ready output. It sits between the MixColumns/ShiftRows datapath and the round controller in the AES core.

## Interface
- DATA_W, 32, XOR slice width per cycle; legal values 8, 16, 32, 64, 128. BEATS = 128/DATA_W.
- NUM_KEYS, 11, round-key bank depth. AW = $clog2(NUM_KEYS).
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_we  in  1  write strobe for the key bank.
- key_addr  in  AW  key slot to write.
- key_wdata  in  128  key value to write.
- in_valid  in  1  input block valid.
- in_ready  out  1  block accepted when in_valid and in_ready are both high.
- in_state  in  128  state to combine.
- in_round  in  AW  key slot to apply.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  128  state XOR key.
- out_err  out  1  in_round was >= NUM_KEYS for this result.
- busy  out  1  high in BUSY and DONE.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset takes the FSM to IDLE.
- IDLE: in_ready=1. On accept:
  - capture in_state into work register W.
  - snapshot key[in_round] into register K. If in_round >= NUM_KEYS, K=0 and err_q=1; otherwise err_q=0.
  - clear beat counter; go to BUSY.
- BUSY: in_ready=0.
  - beat b (0..BEATS-1): W[b*DATA_W +: DATA_W] ^= K[b*DATA_W +: DATA_W]. Lowest slice first.
  - after beat BEATS-1, go to DONE.
- DONE: out_valid=1, out_data=W, out_err=err_q. All three are held stable until out_ready=1, then return to IDLE.
- Key bank:
  - key_we writes key_wdata to key_addr in any state; the write is visible from the next cycle.
  - key_we with key_addr >= NUM_KEYS is dropped.
  - an in-flight block uses its snapshot K, so bank writes never affect it.
  - key_we at the same key_addr/in_round on the accept cycle: the snapshot takes the old value (read before write).
- in_valid is ignored outside IDLE. Nothing queues.
- Reset mid-operation abandons the block. No output is produced for it.

## Timing
- Reset values:
  - in_ready=0 during rst, 1 from the first cycle after rst deasserts.
  - out_valid=0, out_data=0, out_err=0, busy=0.
  - all key slots = 0, W=0, K=0.
- Accept at cycle t: BUSY occupies cycles t+1..t+BEATS; out_valid first high at cycle t+BEATS+1.
  - DATA_W=32: result at t+5.
  - DATA_W=128: result at t+2.
- With out_ready held high, the handshake completes in the first DONE cycle. IDLE is reached the next cycle, so the minimum block period is BEATS+2 cycles.
- out_ready low: DONE holds indefinitely with outputs frozen.
- All outputs are registered. No combinational path runs from any input to any output.

## Configuration
- ARK_KEY_CLEAR_EN defined: adds input port key_clr (1 bit).
  - key_clr=1 zeroes every key slot and K on the next edge.
  - key_clr overrides key_we in the same cycle.
  - a block in BUSY/DONE completes, but its remaining beats use K=0.
- ARK_KEY_CLEAR_EN undefined: key_clr does not exist; key slots change only via key_we or rst.

## Test plan
- Run with DATA_W=32. Write key[0]=000102030405060708090a0b0c0d0e0f, then send state 00112233445566778899aabbccddeeff with round 0 accepted at cycle t.
  - Required: out_data=00102030405060708090a0b0c0d0e0f0, out_err=0, out_valid rising at t+5.
- Send round=NUM_KEYS (11) with state 0123...ef.
  - Required: out_data equals the input unchanged, out_err=1.
- Assert key_we to the active slot (value ffff...ff) on the accept cycle and again during BUSY.
  - Required: the result uses the old key; a second block with the same round uses ffff...ff.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid.
  - Required: out_data stable, in_ready=0, no extra accept. Raising out_ready gives one handshake, then in_ready=1 the next cycle.
- Assert rst during BUSY beat 2.
  - Required: next cycle out_valid=0, busy=0, all keys read back as zero (a block with round 0 returns its input).
  - ARK_KEY_CLEAR_EN build: key_clr together with key_we gives an all-zero key.

Source files
------------

// File: rtl/add_round_keys_seq.sv
// Sequential AddRoundKey: XORs a 128-bit state with a banked round key, DATA_W bits per cycle.
// Define ARK_KEY_CLEAR_EN to add the key_clr port that wipes the key bank and the key snapshot.
module add_round_keys_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_KEYS = 11,
  localparam int AW      = $clog2(NUM_KEYS)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ARK_KEY_CLEAR_EN
  input  logic          key_clr,
`endif
  input  logic          key_we,
  input  logic [AW-1:0] key_addr,
  input  logic [127:0]  key_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_state,
  input  logic [AW-1:0] in_round,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          out_err,
  output logic          busy
);

  localparam int BEATS = 128 / DATA_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [AW:0]   NK   = (AW + 1)'(NUM_KEYS);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [127:0]    keys_r [NUM_KEYS];
  logic [127:0]    w_r, k_r, w_next_s, k_sel_s;
  logic            err_r;
  logic [CW-1:0]   cnt_r;
  logic            accept_s, round_ok_s, addr_ok_s;
  logic            in_ready_s, out_valid_s, busy_s;

  assign accept_s   = in_valid & in_ready;
  assign round_ok_s = ({1'b0, in_round} < NK);
  assign addr_ok_s  = ({1'b0, key_addr} < NK);
  assign out_data   = w_r;
  assign out_err    = err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = BUSY;
        else          state_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == LAST) state_s = DONE;
        else               state_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake/status flags decoded from the upcoming state, then registered.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_s)
      IDLE:    in_ready_s = 1'b1;
      BUSY:    busy_s = 1'b1;
      DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_s;
      out_valid <= out_valid_s;
      busy      <= busy_s;
    end
  end

  // Key selection for the snapshot; out-of-range rounds apply an all-zero key.
  always_comb begin
    if (round_ok_s) k_sel_s = keys_r[in_round];
    else            k_sel_s = 128'd0;
  end

  // One DATA_W slice per beat, lowest slice first.
  always_comb begin
    w_next_s = w_r;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt_r == CW'(b)) w_next_s[b*DATA_W +: DATA_W] = w_r[b*DATA_W +: DATA_W] ^ k_r[b*DATA_W +: DATA_W];
      else                 w_next_s[b*DATA_W +: DATA_W] = w_r[b*DATA_W +: DATA_W];
    end
  end

  // Work register, key snapshot, error flag and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_r   <= 128'd0;
      k_r   <= 128'd0;
      err_r <= 1'b0;
      cnt_r <= CW'(0);
    end else begin
      if (accept_s) begin
        w_r   <= in_state;
        k_r   <= k_sel_s;
        err_r <= ~round_ok_s;
        cnt_r <= CW'(0);
      end else if (state_r == BUSY) begin
        w_r   <= w_next_s;
        cnt_r <= cnt_r + CW'(1);
      end
`ifdef ARK_KEY_CLEAR_EN
      if (key_clr) k_r <= 128'd0;
`endif
    end
  end

  // Key bank; the snapshot above reads the pre-write value on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) keys_r[i] <= 128'd0;
`ifdef ARK_KEY_CLEAR_EN
    end else if (key_clr) begin
      for (int i = 0; i < NUM_KEYS; i++) keys_r[i] <= 128'd0;
`endif
    end else if (key_we && addr_ok_s) begin
      keys_r[key_addr] <= key_wdata;
    end
  end

endmodule

// File: tb/tb_add_round_keys_seq.sv
// Randomized self-checking bench for add_round_keys_seq against a whole-block XOR reference model.
// Build with ARK_KEY_CLEAR_EN defined to also exercise key_clr.
module tb_add_round_keys_seq;

  localparam int DATA_W   = 32;
  localparam int NUM_KEYS = 11;
  localparam int BEATS    = 128 / DATA_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
`ifdef ARK_KEY_CLEAR_EN
  logic         key_clr = 1'b0;
`endif
  logic         key_we = 1'b0;
  logic [3:0]   key_addr = 4'd0;
  logic [127:0] key_wdata = 128'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = 128'd0;
  logic [3:0]   in_round = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_err;
  logic         busy;

  int compared = 0;
  int mismatched = 0;
  logic [127:0] mkeys [16];

  always #5 clk = ~clk;

  add_round_keys_seq #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS)) dut (
    .clk(clk), .rst(rst),
`ifdef ARK_KEY_CLEAR_EN
    .key_clr(key_clr),
`endif
    .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic write_key(input logic [3:0] a, input logic [127:0] v);
    key_addr = a; key_wdata = v; key_we = 1'b1;
    tick();
    key_we = 1'b0;
    if (a < NUM_KEYS) mkeys[a] = v;
  endtask

  task automatic run_block(input logic [127:0] st, input logic [3:0] rnd,
                           output logic [127:0] data, output logic err, output int lat);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    in_state = st; in_round = rnd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
    data = out_data; err = out_err;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    compared++;
    if ({in_ready, out_valid, busy, out_err} !== 4'b0000 || out_data !== 128'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b err=%b data=%h want all zero",
               in_ready, out_valid, busy, out_err, out_data);
    end
    rst = 1'b0;
    tick();
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 16; i++) mkeys[i] = 128'd0;
  endtask

  task automatic test_known_vector();
    logic [127:0] d; logic e; int lat;
    write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    run_block(128'h00112233445566778899aabbccddeeff, 4'd0, d, e, lat);
    compared++;
    if (d !== 128'h00102030405060708090a0b0c0d0e0f0 || e !== 1'b0) begin
      mismatched++;
      $display("FAIL known_vector: got %h err=%b want 00102030405060708090a0b0c0d0e0f0 err=0", d, e);
    end
    compared++;
    if (lat !== BEATS + 1) begin
      mismatched++;
      $display("FAIL known_latency: got %0d want %0d", lat, BEATS + 1);
    end
  endtask

  task automatic test_bad_round();
    logic [127:0] d; logic e; int lat;
    logic [127:0] st = 128'h0123456789abcdef0123456789abcdef;
    write_key(4'd11, 128'hdeadbeef);
    run_block(st, 4'd11, d, e, lat);
    compared++;
    if (d !== st || e !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_round11: got %h err=%b want %h err=1", d, e, st);
    end
    run_block(~st, 4'd15, d, e, lat);
    compared++;
    if (d !== ~st || e !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_round15: got %h err=%b want %h err=1", d, e, ~st);
    end
  endtask

  task automatic test_random();
    logic [127:0] d, st, exp; logic e, experr; int lat; logic [3:0] rnd;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) write_key(4'($urandom_range(0, 15)), rand128());
      st  = rand128();
      rnd = 4'($urandom_range(0, 12));
      experr = (rnd >= NUM_KEYS);
      exp = experr ? st : (st ^ mkeys[rnd]);
      run_block(st, rnd, d, e, lat);
      compared++;
      if (d !== exp || e !== experr || lat !== BEATS + 1) begin
        mismatched++;
        $display("FAIL random[%0d]: got %h err=%b lat=%0d want %h err=%b lat=%0d",
                 it, d, e, lat, exp, experr, BEATS + 1);
      end
    end
  endtask

  task automatic test_key_write_race();
    logic [127:0] old, st, d; logic e; int lat;
    old = rand128(); st = rand128();
    write_key(4'd3, old);
    in_state = st; in_round = 4'd3; in_valid = 1'b1;
    key_addr = 4'd3; key_wdata = {128{1'b1}}; key_we = 1'b1;
    tick();
    in_valid = 1'b0; key_we = 1'b0;
    mkeys[3] = {128{1'b1}};
    tick();
    key_we = 1'b1;
    tick();
    key_we = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
    compared++;
    if (out_data !== (st ^ old) || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL race_old_key: got %h vld=%b want %h", out_data, out_valid, st ^ old);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    run_block(st, 4'd3, d, e, lat);
    compared++;
    if (d !== ~st) begin
      mismatched++;
      $display("FAIL race_new_key: got %h want %h", d, ~st);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] st, exp; int lat;
    st = rand128(); exp = st ^ mkeys[5];
    in_state = st; in_round = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0); in_state = rand128(); in_round = 4'd0;
      tick();
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
        mismatched++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b data=%h want vld=1 rdy=0 data=%h",
                 i, out_valid, in_ready, out_data, exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_release: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] st, exp; int last, gaps;
    st = rand128(); exp = st ^ mkeys[7];
    in_state = st; in_round = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
    last = -1; gaps = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        compared++;
        if (out_data !== exp || (last >= 0 && c - last !== BEATS + 2)) begin
          mismatched++;
          $display("FAIL b2b[%0d]: got %h gap=%0d want %h gap=%0d", c, out_data, c - last, exp, BEATS + 2);
        end
        if (last >= 0) gaps++;
        last = c;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    compared++;
    if (gaps < 3) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d gaps want >= 3", gaps);
    end
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [127:0] st, d; logic e; int lat;
    write_key(4'd0, rand128() | 128'd1);
    st = rand128();
    in_state = st; in_round = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midop_reset: got vld=%b busy=%b want 0 0", out_valid, busy);
    end
    for (int i = 0; i < 16; i++) mkeys[i] = 128'd0;
    run_block(st, 4'd0, d, e, lat);
    compared++;
    if (d !== st || e !== 1'b0) begin
      mismatched++;
      $display("FAIL midop_keys_zero: got %h err=%b want %h err=0", d, e, st);
    end
  endtask

`ifdef ARK_KEY_CLEAR_EN
  task automatic test_key_clear();
    logic [127:0] st, d; logic e; int lat;
    write_key(4'd2, rand128() | 128'd1);
    key_clr = 1'b1; key_we = 1'b1; key_addr = 4'd2; key_wdata = rand128() | 128'd1;
    tick();
    key_clr = 1'b0; key_we = 1'b0;
    for (int i = 0; i < 16; i++) mkeys[i] = 128'd0;
    st = rand128();
    run_block(st, 4'd2, d, e, lat);
    compared++;
    if (d !== st) begin
      mismatched++;
      $display("FAIL key_clear: got %h want %h", d, st);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_vector();
    test_bad_round();
    test_random();
    test_key_write_race();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef ARK_KEY_CLEAR_EN
    test_key_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
